fn_desp_izq_sec: RTL



---
 rtl/fn_desp_izq_sec_if.sv | 19 +
 rtl/fn_desp_izq_sec.sv | 99 +++++++++
 2 files changed

// File: rtl/fn_desp_izq_sec_if.sv
// Handshake and data bundle for the iterative left shifter fn_desp_izq_sec.
// The master side issues a start with operand and shift amount. The slave side
// reports busy, a done pulse and the held result.
interface fn_desp_izq_sec_if #(
  parameter int ANCHO   = 32,
  parameter int ANCHO_B = 5
);
  logic               inicio;
  logic [ANCHO-1:0]   a;
  logic [ANCHO_B-1:0] b;
  logic               ocupado;
  logic               listo;
  logic [ANCHO-1:0]   Y;

  modport master (output inicio, output a, output b,
                  input  ocupado, input listo, input Y);
  modport slave  (input  inicio, input a, input b,
                  output ocupado, output listo, output Y);
endinterface

// File: rtl/fn_desp_izq_sec.sv
// fn_desp_izq_sec: sequential logical left shifter (SLL/SLLI) for RV32I.
// By default it shifts the operand one bit per clock. The result register Y
// changes only when an operation finishes or on reset.
// Optional macro DESP_IZQ_PASO4_EN adds a 4-bit step whenever at least four
// positions remain. This shortens latency and gives identical results.
module fn_desp_izq_sec #(
  parameter int ANCHO   = 32,
  parameter int ANCHO_B = 5
) (
  input  logic                 clk,
  input  logic                 nreset,
  fn_desp_izq_sec_if.slave     bus
);

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    DESPLAZA = 2'b01,
    LISTO    = 2'b10
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [ANCHO-1:0]   r_q, r_d;
  logic [ANCHO_B-1:0] cnt_q, cnt_d;
  logic [ANCHO-1:0]   y_q, y_d;
  logic               listo_q, listo_d;
  logic               ocupado_q, ocupado_d;

  // Next-state, shift datapath and registered-output computation
  always_comb begin
    estado_d = estado_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    case (estado_q)
      REPOSO: begin
        if (bus.inicio) begin
          r_d      = bus.a;
          cnt_d    = bus.b;
          estado_d = DESPLAZA;
        end else begin
          estado_d = REPOSO;
        end
      end
      DESPLAZA: begin
        if (cnt_q == {ANCHO_B{1'b0}}) begin
          y_d      = r_q;
          estado_d = LISTO;
        end else begin
`ifdef DESP_IZQ_PASO4_EN
          if (cnt_q >= ANCHO_B'(3'd4)) begin
            r_d   = {r_q[ANCHO-5:0], 4'b0000};
            cnt_d = cnt_q - ANCHO_B'(3'd4);
          end else begin
            r_d   = {r_q[ANCHO-2:0], 1'b0};
            cnt_d = cnt_q - ANCHO_B'(1'b1);
          end
`else
          r_d   = {r_q[ANCHO-2:0], 1'b0};
          cnt_d = cnt_q - ANCHO_B'(1'b1);
`endif
        end
      end
      LISTO: begin
        // No acceptance from LISTO; always pass through REPOSO.
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
    // Outputs are registered copies of what the next state implies.
    listo_d   = (estado_d == LISTO);
    ocupado_d = (estado_d != REPOSO);
  end

  // State, datapath and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q  <= REPOSO;
      r_q       <= {ANCHO{1'b0}};
      cnt_q     <= {ANCHO_B{1'b0}};
      y_q       <= {ANCHO{1'b0}};
      listo_q   <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      listo_q   <= listo_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.Y       = y_q;
  assign bus.listo   = listo_q;
  assign bus.ocupado = ocupado_q;

endmodule
